pc_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch for the single-issue MIPS datapath.
- Computes PC+4 internally and selects the next PC from sequential, branch and jump sources.
- Drives a req/ack handshake to instruction memory, which may take several cycles.
- Absorbs hazard-unit stalls and datapath redirects, and squashes fetches made stale by a redirect.

---
 rtl/pc_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and instruction fetch sequencer for the single-issue MIPS datapath.
// Holds the PC, runs the req/ack fetch handshake and squashes fetches overtaken by a redirect.
module pc_sequencer #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Stall,
    input  logic            BranchTaken,
    input  logic [PC_W-1:0] BranchTarget,
    input  logic            Jump,
    input  logic [PC_W-1:0] JumpTarget,
    input  logic            Halt,
    output logic            IMemReq,
    output logic [PC_W-1:0] IMemAddr,
    input  logic            IMemAck,
    output logic [PC_W-1:0] PCResult,
    output logic [PC_W-1:0] PCAddResult,
    output logic            FetchValid,
    output logic [PC_W-1:0] FetchPC
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_n;
    logic [PC_W-1:0] pc_add;
    logic            req;
    logic            req_n;
    logic            fetch_valid;
    logic            fetch_valid_n;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] fetch_pc_n;
    logic            pend_redir;
    logic            pend_redir_n;
    logic [PC_W-1:0] pend_tgt;
    logic [PC_W-1:0] pend_tgt_n;
    logic            pend_halt;
    logic            pend_halt_n;
    logic            redir;
    logic [PC_W-1:0] redir_tgt;
    logic [PC_W-1:0] raw_tgt;

    assign pc_add = pc + PC_W'(4);

    // Jump wins over a same-cycle taken branch; targets are word aligned.
    assign redir     = Jump | BranchTaken;
    assign raw_tgt   = Jump ? JumpTarget : BranchTarget;
    assign redir_tgt = {raw_tgt[PC_W-1:2], 2'b00};

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        fetch_valid_n = 1'b0;
        fetch_pc_n    = fetch_pc;
        pend_redir_n  = pend_redir;
        pend_tgt_n    = pend_tgt;
        pend_halt_n   = pend_halt;
        case (state)
            IDLE: begin
                if (redir) pc_n = redir_tgt;
                if (Halt) state_n = HALT;
                else if (!Stall) state_n = REQ;
            end
            REQ: begin
                if (IMemAck) begin
                    fetch_pc_n    = pc;
                    fetch_valid_n = !(redir || pend_redir || Halt || pend_halt);
                    if (redir) pc_n = redir_tgt;
                    else if (pend_redir) pc_n = pend_tgt;
                    else pc_n = pc_add;
                    pend_redir_n = 1'b0;
                    pend_halt_n  = 1'b0;
                    if (Halt || pend_halt) state_n = HALT;
                    else if (Stall) state_n = IDLE;
                end else begin
                    // Request is held stable; remember what arrived meanwhile.
                    if (redir) begin
                        pend_redir_n = 1'b1;
                        pend_tgt_n   = redir_tgt;
                    end
                    if (Halt) pend_halt_n = 1'b1;
                end
            end
            HALT: begin
                state_n = HALT;
            end
            default: state_n = IDLE;
        endcase
        req_n = (state_n == REQ);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req         <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            pend_redir  <= 1'b0;
            pend_tgt    <= '0;
            pend_halt   <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            req         <= req_n;
            fetch_valid <= fetch_valid_n;
            fetch_pc    <= fetch_pc_n;
            pend_redir  <= pend_redir_n;
            pend_tgt    <= pend_tgt_n;
            pend_halt   <= pend_halt_n;
        end
    end

    assign IMemReq     = req;
    assign IMemAddr    = pc;
    assign PCResult    = pc;
    assign PCAddResult = pc_add;
    assign FetchValid  = fetch_valid;
    assign FetchPC     = fetch_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed fetch scenarios with
// a scoreboard of expected completed fetches.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Halt;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        FetchValid;
    logic [31:0] FetchPC;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
    } fetch_t;

    fetch_t sb[$];
    int     total = 0;
    int     bad = 0;
    logic   hs_q = 1'b0;
    logic   mon_en = 1'b0;

    pc_sequencer #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Stall(Stall),
        .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump(Jump),
        .JumpTarget(JumpTarget),
        .Halt(Halt),
        .IMemReq(IMemReq),
        .IMemAddr(IMemAddr),
        .IMemAck(IMemAck),
        .PCResult(PCResult),
        .PCAddResult(PCAddResult),
        .FetchValid(FetchValid),
        .FetchPC(FetchPC)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic valid);
        fetch_t e;
        e.pc    = pc;
        e.valid = valid;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic expect_req(input string tag, input logic [31:0] addr);
        check({tag, "_req"}, 32'(IMemReq), 32'd1);
        check({tag, "_addr"}, IMemAddr, addr);
    endtask

    // Record each handshake the DUT sees at the clock edge.
    always @(posedge Clk) begin
        hs_q <= IMemReq && IMemAck && !Reset;
    end

    always @(negedge Clk) begin
        if (mon_en) begin
            if (hs_q) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    fetch_t e;
                    e = sb.pop_front();
                    check("fetch_valid", 32'(FetchValid), 32'(e.valid));
                    check("fetch_pc", FetchPC, e.pc);
                end
            end else begin
                check("fv_no_ack", 32'(FetchValid), 32'd0);
            end
        end
    end

    initial begin
        Reset = 1'b1;
        Stall = 1'b0;
        BranchTaken = 1'b0;
        BranchTarget = '0;
        Jump = 1'b0;
        JumpTarget = '0;
        Halt = 1'b0;
        IMemAck = 1'b0;
        tick();
        tick();
        check("rst_pc", PCResult, 32'h0);
        check("rst_req", 32'(IMemReq), 32'd0);
        check("rst_fv", 32'(FetchValid), 32'd0);
        check("rst_fpc", FetchPC, 32'h0);
        check("rst_pc4", PCAddResult, 32'h4);
        mon_en = 1'b1;

        // Zero-wait memory: one fetch per cycle.
        Reset = 1'b0;
        IMemAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_req("seq", 32'(i * 4));
            push(32'(i * 4), 1'b1);
        end

        // Three-cycle wait at 0x10 with a stall pulse.
        tick();
        expect_req("w0", 32'h10);
        IMemAck = 1'b0;
        tick();
        expect_req("w1", 32'h10);
        Stall = 1'b1;
        tick();
        expect_req("w2", 32'h10);
        Stall = 1'b0;
        tick();
        expect_req("w3", 32'h10);
        IMemAck = 1'b1;
        push(32'h10, 1'b1);
        tick();
        expect_req("after_wait", 32'h14);
        check("pc4_14", PCAddResult, 32'h18);
        Stall = 1'b1;
        push(32'h14, 1'b1);
        tick();
        check("stall_idle_req", 32'(IMemReq), 32'd0);
        check("stall_idle_pc", PCResult, 32'h18);
        Stall = 1'b0;
        IMemAck = 1'b0;
        tick();
        expect_req("resume", 32'h18);
        IMemAck = 1'b1;
        push(32'h18, 1'b1);
        tick();
        expect_req("s1c", 32'h1C);
        push(32'h1C, 1'b1);

        // Branch while waiting at 0x20.
        tick();
        expect_req("br_wait0", 32'h20);
        IMemAck = 1'b0;
        BranchTaken = 1'b1;
        BranchTarget = 32'h40;
        tick();
        BranchTaken = 1'b0;
        BranchTarget = 32'h0;
        expect_req("br_wait1", 32'h20);
        tick();
        expect_req("br_wait2", 32'h20);
        IMemAck = 1'b1;
        push(32'h20, 1'b0);
        tick();
        expect_req("br_tgt", 32'h40);
        push(32'h40, 1'b1);

        // Jump and branch together with the ack: jump wins, aligned.
        tick();
        expect_req("jb0", 32'h44);
        Jump = 1'b1;
        JumpTarget = 32'h103;
        BranchTaken = 1'b1;
        BranchTarget = 32'h80;
        push(32'h44, 1'b0);
        tick();
        BranchTaken = 1'b0;
        expect_req("jb_tgt", 32'h100);

        // Wrap around the top of the address space.
        JumpTarget = 32'hFFFF_FFFC;
        push(32'h100, 1'b0);
        tick();
        Jump = 1'b0;
        expect_req("wrap0", 32'hFFFF_FFFC);
        check("wrap_pc4", PCAddResult, 32'h0);
        push(32'hFFFF_FFFC, 1'b1);
        tick();
        expect_req("wrap1", 32'h0);

        // Halt while waiting, then ack; redirects afterwards are ignored.
        IMemAck = 1'b0;
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        expect_req("halt_wait", 32'h0);
        IMemAck = 1'b1;
        push(32'h0, 1'b0);
        tick();
        check("halt_req", 32'(IMemReq), 32'd0);
        check("halt_pc", PCResult, 32'h4);
        BranchTaken = 1'b1;
        BranchTarget = 32'h200;
        Jump = 1'b1;
        JumpTarget = 32'h300;
        tick();
        BranchTaken = 1'b0;
        Jump = 1'b0;
        check("halt_hold_req", 32'(IMemReq), 32'd0);
        check("halt_hold_pc", PCResult, 32'h4);
        tick();
        check("halt_hold2_req", 32'(IMemReq), 32'd0);

        // Reset pulse restarts fetch from RESET_PC.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst2_pc", PCResult, 32'h0);
        check("rst2_req", 32'(IMemReq), 32'd0);
        check("rst2_fpc", FetchPC, 32'h0);
        tick();
        expect_req("rst2_f0", 32'h0);
        push(32'h0, 1'b1);
        tick();
        expect_req("rst2_f1", 32'h4);
        IMemAck = 1'b0;
        tick();
        tick();
        expect_req("rst2_hold", 32'h4);
        check("sb_left", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
